note_voice: RTL

NOTE_VOICE -- requirements
Module: note_voice

---
 rtl/sass_pkg.sv | 25 ++
 rtl/note_period_lut.sv | 17 +
 rtl/note_voice.sv | 117 +++++++++++
 3 files changed

// File: rtl/sass_pkg.sv
// Shared definitions for the note voice: note table, state encoding and
// audio constants used by the voice and its period lookup.
package sass_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [7:0] MIDSCALE  = 8'd128;

  // Half-period in clock cycles for notes 1..8 (C4..C5), indexed by note-1.
  typedef logic [4:0] half_period_tbl_t [8];
  localparam half_period_tbl_t HALF_PERIOD = '{
    5'd19, 5'd17, 5'd15, 5'd14, 5'd13, 5'd11, 5'd10, 5'd9
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } voice_state_t;

  function automatic logic note_valid(input logic [3:0] note);
    return (note != NOTE_REST) && (note <= 4'd8);
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational note code to square-wave half-period lookup; rest codes map
// to zero.
module note_period_lut
  import sass_pkg::*;
(
  input  logic [3:0] note,
  output logic [4:0] half_period
);

  always_comb begin
    half_period = '0;
    if (note_valid(note)) begin
      half_period = HALF_PERIOD[3'(note - 4'd1)];
    end
  end

endmodule

// File: rtl/note_voice.sv
// Single square-wave voice with a linear attack/sustain/release envelope,
// driven by a registered note code from the sequencer.
module note_voice
  import sass_pkg::*;
#(
  parameter int unsigned ENV_STEP = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] note_sustain,
  output logic [7:0] sample,
  output logic       wave,
  output logic       active
);

  localparam int unsigned PW = $clog2(ENV_STEP);
  localparam logic [PW-1:0] PRESC_LAST = PW'(ENV_STEP - 1);

  logic [3:0]    note_q;
  voice_state_t  state, state_n;
  logic [3:0]    env, env_n;
  logic [PW-1:0] presc;
  logic [4:0]    phase;
  logic [4:0]    period;
  logic [4:0]    pend;
  logic          wave_q;
  logic [4:0]    lut_hp;
  logic          note_ok;
  logic          tick;

  note_period_lut u_lut (
    .note        (note_q),
    .half_period (lut_hp)
  );

  assign note_ok = note_valid(note_q);
  assign tick    = (state != IDLE) && (presc == PRESC_LAST);

  // A tick coinciding with a transition is applied under the current state's
  // rule first; the transition then sees the updated envelope.
  always_comb begin
    state_n = state;
    env_n   = env;
    unique case (state)
      IDLE: begin
        if (note_ok) begin
          state_n = ATTACK;
          env_n   = '0;
        end
      end
      ATTACK: begin
        if (tick && (env != 4'd15)) env_n = env + 4'd1;
        if (!note_ok)               state_n = RELEASE;
        else if (env_n == 4'd15)    state_n = SUSTAIN;
      end
      SUSTAIN: begin
        if (!note_ok) state_n = RELEASE;
      end
      RELEASE: begin
        if (tick && (env != 4'd0)) env_n = env - 4'd1;
        if (note_ok)               state_n = ATTACK;
        else if (env_n == 4'd0)    state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      note_q <= NOTE_REST;
      state  <= IDLE;
      env    <= '0;
      presc  <= '0;
      phase  <= '0;
      period <= HALF_PERIOD[0];
      pend   <= HALF_PERIOD[0];
      wave_q <= 1'b0;
      sample <= MIDSCALE;
    end else begin
      note_q <= note_sustain;
      state  <= state_n;
      env    <= env_n;

      if (note_ok) pend <= lut_hp;

      if (state == IDLE) presc <= '0;
      else if (tick)     presc <= '0;
      else               presc <= presc + 1'b1;

      // New pitch only lands at a half-period boundary to avoid glitches.
      if (state == IDLE) begin
        phase <= '0;
        if (note_ok) begin
          period <= lut_hp;
          wave_q <= 1'b1;
        end
      end else if (state_n == IDLE) begin
        phase  <= '0;
        wave_q <= 1'b0;
      end else if (phase == period - 5'd1) begin
        phase  <= '0;
        wave_q <= ~wave_q;
        period <= pend;
      end else begin
        phase <= phase + 5'd1;
      end

      if (state == IDLE)  sample <= MIDSCALE;
      else if (wave_q)    sample <= MIDSCALE + {1'b0, env, 3'b000};
      else                sample <= MIDSCALE - {1'b0, env, 3'b000};
    end
  end

  assign wave   = wave_q;
  assign active = (state != IDLE);

endmodule
